// File: rtl/audio_seq.sv
// Audio playback sequencer: period/duration registers, square-wave tone
// generator and a one-cycle release pulse when a programmed note ends.
module audio_seq #(
  parameter int DATA_W   = 8,
  parameter int TICK_DIV = 50000,
  parameter int PRE_DIV  = 500
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              audioreg,
  input  logic              audioact,
  input  logic              s_cont,
  input  logic [DATA_W-1:0] data,
  output logic              cont,
  output logic              busy,
  output logic              speaker
);

  localparam int MS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PRE_W = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] per_reg, per_nx;
  logic [DATA_W-1:0] dur_reg, dur_nx;
  logic [DATA_W-1:0] dur_cnt, dur_cnt_nx;
  logic [MS_W-1:0]   ms_cnt, ms_nx;
  logic [PRE_W-1:0]  pre_cnt, pre_nx;
  logic [DATA_W-1:0] half_cnt, half_nx;
  logic              spk_q, spk_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      per_reg  <= '0;
      dur_reg  <= '0;
      dur_cnt  <= '0;
      ms_cnt   <= '0;
      pre_cnt  <= '0;
      half_cnt <= '0;
      spk_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      per_reg  <= per_nx;
      dur_reg  <= dur_nx;
      dur_cnt  <= dur_cnt_nx;
      ms_cnt   <= ms_nx;
      pre_cnt  <= pre_nx;
      half_cnt <= half_nx;
      spk_q    <= spk_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    per_nx     = per_reg;
    dur_nx     = dur_reg;
    dur_cnt_nx = dur_cnt;
    ms_nx      = ms_cnt;
    pre_nx     = pre_cnt;
    half_nx    = half_cnt;
    spk_nx     = spk_q;

    if (audioreg)
      dur_nx = data;
    if (audioact && s_cont)
      per_nx = data;

    unique case (state)
      IDLE: begin
        spk_nx = 1'b0;
        if (audioact && !s_cont) begin
          state_nx   = PLAY;
          dur_cnt_nx = dur_reg;
          ms_nx      = '0;
          pre_nx     = '0;
          half_nx    = '0;
        end
      end

      PLAY: begin
        if (dur_cnt != '0) begin
          if (ms_cnt == MS_LAST) begin
            ms_nx      = '0;
            dur_cnt_nx = dur_cnt - DATA_W'(1);
          end else begin
            ms_nx = ms_cnt + MS_W'(1);
          end
        end else begin
          state_nx = DONE;
        end

        if (pre_cnt == PRE_LAST)
          pre_nx = '0;
        else
          pre_nx = pre_cnt + PRE_W'(1);

        // >= rather than == so a shortened period never lets half_cnt run past it
        if (per_reg == '0) begin
          spk_nx = 1'b0;
        end else if (pre_cnt == PRE_LAST) begin
          if (half_cnt >= per_reg - DATA_W'(1)) begin
            half_nx = '0;
            spk_nx  = ~spk_q;
          end else begin
            half_nx = half_cnt + DATA_W'(1);
          end
        end

        if (dur_cnt == '0)
          spk_nx = 1'b0;
      end

      DONE: begin
        state_nx = IDLE;
        spk_nx   = 1'b0;
      end

      default: begin
        state_nx = IDLE;
        spk_nx   = 1'b0;
      end
    endcase
  end

  assign cont    = (state == DONE);
  assign busy    = (state != IDLE);
  assign speaker = spk_q;

endmodule

// File: tb/tb_audio_seq.sv
// Self-checking bench for audio_seq: directed scenarios plus randomized notes
// compared against a per-cycle timing model derived from note length and period.
module tb_audio_seq;

  localparam int T  = 4;
  localparam int PR = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       audioreg;
  logic       audioact;
  logic       s_cont;
  logic [7:0] data;
  logic       cont;
  logic       busy;
  logic       speaker;

  int errors = 0;
  int checks = 0;
  int m_per  = 0;
  int m_dur  = 0;

  always #5 clk = ~clk;

  audio_seq #(
    .DATA_W  (8),
    .TICK_DIV(T),
    .PRE_DIV (PR)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .audioreg(audioreg),
    .audioact(audioact),
    .s_cont  (s_cont),
    .data    (data),
    .cont    (cont),
    .busy    (busy),
    .speaker (speaker)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input bit eb, input bit ec, input bit es);
    chk({tag, "_busy"},    32'(busy),    32'(eb));
    chk({tag, "_cont"},    32'(cont),    32'(ec));
    chk({tag, "_speaker"}, 32'(speaker), 32'(es));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Speaker level during PLAY cycle k (1-based): toggles every per*PR cycles.
  function automatic bit exp_spk(input int per, input int k);
    if (per == 0) return 1'b0;
    return (((k - 1) / (per * PR)) % 2) == 1;
  endfunction

  task automatic load_dur(input int d);
    audioreg = 1'b1;
    data     = 8'(d);
    step();
    audioreg = 1'b0;
    m_dur    = d;
  endtask

  task automatic load_per(input int p);
    audioact = 1'b1;
    s_cont   = 1'b1;
    data     = 8'(p);
    step();
    audioact = 1'b0;
    m_per    = p;
  endtask

  task automatic request();
    audioact = 1'b1;
    s_cont   = 1'b0;
    step();
  endtask

  // Entered at cycle 1 after the request edge; returns at the idle cycle after DONE.
  task automatic run_note(input int per, input int dur, input bit hold,
                          input bit reload, input int newdur);
    int p;
    p = dur * T + 1;
    for (int k = 1; k <= p + 1; k++) begin
      chk_out($sformatf("note_p%0d_d%0d_k%0d", per, dur, k), 1'b1, k == p + 1,
              (k <= p) ? exp_spk(per, k) : 1'b0);
      if (k == 1) begin
        audioact = hold;
        s_cont   = 1'b0;
      end
      audioreg = reload && (k == 2);
      if (reload && k == 2) data = 8'(newdur);
      step();
    end
    audioreg = 1'b0;
    if (reload) m_dur = newdur;
    chk_out($sformatf("gap_p%0d_d%0d", per, dur), 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [15:0] pat;
    bit hold, reload;
    int nd;

    reset    = 1'b1;
    audioreg = 1'b0;
    audioact = 1'b0;
    s_cont   = 1'b0;
    data     = '0;

    // asynchronous reset before any clock edge
    #2 reset = 1'b0;
    #1 chk_out("rst_async", 1'b0, 1'b0, 1'b0);
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_out("rst_idle", 1'b0, 1'b0, 1'b0);
    end

    // basic note
    load_dur(3);
    load_per(2);
    chk_out("per_load_no_play", 1'b0, 1'b0, 1'b0);
    request();
    run_note(2, 3, 1'b0, 1'b0, 0);

    // zero duration
    load_dur(0);
    request();
    run_note(2, 0, 1'b0, 1'b0, 0);

    // rest
    load_per(0);
    load_dur(2);
    request();
    run_note(0, 2, 1'b0, 1'b0, 0);

    // back-to-back with audioact held
    load_per(1);
    load_dur(1);
    request();
    run_note(1, 1, 1'b1, 1'b0, 0);
    step();
    run_note(1, 1, 1'b0, 1'b0, 0);

    // duration load on the request edge is not seen by that note
    audioreg = 1'b1;
    data     = 8'd4;
    audioact = 1'b1;
    s_cont   = 1'b0;
    step();
    audioreg = 1'b0;
    run_note(1, 1, 1'b0, 1'b0, 0);
    m_dur = 4;
    request();
    run_note(1, 4, 1'b0, 1'b0, 0);

    // period shortened mid-play from 4 to 1
    load_per(4);
    load_dur(3);
    request();
    pat = '0;
    pat[7]  = 1'b1;
    pat[8]  = 1'b1;
    pat[11] = 1'b1;
    pat[12] = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      chk_out($sformatf("perchg_k%0d", k), 1'b1, k == 14, pat[k]);
      audioact = (k == 4);
      s_cont   = (k == 4);
      data     = 8'd1;
      step();
    end
    chk_out("perchg_gap", 1'b0, 1'b0, 1'b0);
    m_per = 1;

    // abort by reset mid-play
    load_dur(5);
    request();
    audioact = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      chk_out($sformatf("abort_play_k%0d", k), 1'b1, 1'b0, exp_spk(1, k));
      if (k < 6) step();
    end
    #2 reset = 1'b0;
    #1 chk_out("abort_async", 1'b0, 1'b0, 1'b0);
    step();
    chk_out("abort_held", 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    chk_out("abort_idle", 1'b0, 1'b0, 1'b0);
    m_per = 0;
    m_dur = 0;
    request();
    run_note(0, 0, 1'b0, 1'b0, 0);

    // randomized notes
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 1) == 1) load_per($urandom_range(0, 5));
      if ($urandom_range(0, 1) == 1) load_dur($urandom_range(0, 4));
      hold   = ($urandom_range(0, 3) == 0);
      reload = ($urandom_range(0, 3) == 0);
      nd     = $urandom_range(0, 4);
      request();
      run_note(m_per, m_dur, hold, reload, nd);
      if (hold) begin
        step();
        run_note(m_per, m_dur, 1'b0, 1'b0, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
